// File: rtl/noc_cap_pkg.sv
// Shared types and default constants for the NoC capture buffer.
package noc_cap_pkg;

  localparam int unsigned FLIT_W_DEF      = 20;
  localparam int unsigned PAYLOAD_LSB_DEF = 4;
  localparam int unsigned NUM_CH_DEF      = 16;
  localparam int unsigned DEPTH_DEF       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/noc_cap_chan.sv
// Per-channel capture ring: payload memory, write pointer, fill count, full and sticky overflow.
module noc_cap_chan
  import noc_cap_pkg::*;
#(
  parameter int unsigned PAY_W = FLIT_W_DEF - PAYLOAD_LSB_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wrap_mode,
  input  logic                       wr_en,
  input  logic [PAY_W-1:0]           payload,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [PAY_W-1:0]           rd_data_c,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       ovf
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [PAY_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_addr;
  logic             is_full;
  logic             accept;
  logic [CNT_W-1:0] count_nxt;

  assign is_full   = (count == CNT_W'(DEPTH));
  assign accept    = wr_en && !clr && (!is_full || wrap_mode);
  assign count_nxt = is_full ? count : count + CNT_W'(1);

  // Oldest entry sits count slots behind the write pointer (0 when full, so origin == wr_ptr).
  assign rd_addr   = wr_ptr - count[IDX_W-1:0] + rd_idx;
  assign rd_data_c = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + IDX_W'(1);
        count  <= count_nxt;
        full   <= (count_nxt == CNT_W'(DEPTH));
      end
      if (wr_en && is_full) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_capture_buffer.sv
// Multi-channel NoC ejection capture with channel-major, oldest-first dump stream.
// Optional per-channel drop counters are built when NOC_CAP_STATS_EN is defined.
module noc_capture_buffer
  import noc_cap_pkg::*;
#(
  parameter int unsigned NUM_CH      = NUM_CH_DEF,
  parameter int unsigned FLIT_W      = FLIT_W_DEF,
  parameter int unsigned PAYLOAD_LSB = PAYLOAD_LSB_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            wrap_mode,
  input  logic [NUM_CH-1:0]               in_valid,
  input  logic [NUM_CH*FLIT_W-1:0]        in_flit,
  input  logic                            dump_start,
  output logic                            dump_valid,
  input  logic                            dump_ready,
  output logic [$clog2(NUM_CH)-1:0]       dump_ch,
  output logic [$clog2(DEPTH)-1:0]        dump_idx,
  output logic [FLIT_W-PAYLOAD_LSB-1:0]   dump_data,
  output logic                            dump_done,
  output logic [NUM_CH-1:0]               full,
  output logic [NUM_CH-1:0]               ovf
`ifdef NOC_CAP_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]            drop_cnt
`endif
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned PAY_W = FLIT_W - PAYLOAD_LSB;

  state_e           state;
  logic             idle;
  logic [PAY_W-1:0] rd_data [NUM_CH];
  logic [CNT_W-1:0] count   [NUM_CH];
  logic [NUM_CH*PAYLOAD_LSB-1:0] hdr_bits;
  logic             unused_hdr;

  logic [CH_W-1:0]  cur_ch;
  logic [CNT_W-1:0] cur_idx;
  logic             found;
  logic [CH_W-1:0]  sel_ch;
  logic [CNT_W-1:0] sel_idx;

  assign idle = (state == IDLE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    assign hdr_bits[c*PAYLOAD_LSB +: PAYLOAD_LSB] = in_flit[c*FLIT_W +: PAYLOAD_LSB];

    noc_cap_chan #(
      .PAY_W (PAY_W),
      .DEPTH (DEPTH)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr && idle),
      .wrap_mode (wrap_mode),
      .wr_en     (in_valid[c] && idle),
      .payload   (in_flit[c*FLIT_W+PAYLOAD_LSB +: PAY_W]),
      .rd_idx    (sel_idx[IDX_W-1:0]),
      .rd_data_c (rd_data[c]),
      .count     (count[c]),
      .full      (full[c]),
      .ovf       (ovf[c])
    );
  end

  assign unused_hdr = ^hdr_bits;

  // Next beat: remaining entry of the cursor channel, else entry 0 of the next non-empty channel.
  always_comb begin
    found   = 1'b0;
    sel_ch  = '0;
    sel_idx = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if ((CH_W'(c) == cur_ch && cur_idx < count[c]) ||
          (CH_W'(c) >  cur_ch && count[c] != '0)) begin
        found   = 1'b1;
        sel_ch  = CH_W'(c);
        sel_idx = (CH_W'(c) == cur_ch) ? cur_idx : '0;
      end
    end
  end

  // Dump sequencer and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      dump_ch    <= '0;
      dump_idx   <= '0;
      dump_data  <= '0;
      cur_ch     <= '0;
      cur_idx    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          dump_done <= 1'b0;
          if (dump_start) begin
            state   <= DUMP;
            cur_ch  <= '0;
            cur_idx <= '0;
          end
        end
        DUMP: begin
          if (!dump_valid || dump_ready) begin
            if (found) begin
              dump_valid <= 1'b1;
              dump_ch    <= sel_ch;
              dump_idx   <= sel_idx[IDX_W-1:0];
              dump_data  <= rd_data[sel_ch];
              cur_ch     <= sel_ch;
              cur_idx    <= sel_idx + CNT_W'(1);
            end else begin
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          dump_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NOC_CAP_STATS_EN
  logic [15:0] drop_q [NUM_CH];

  // Drops: full-and-stop discards while idle, plus any flit arriving during a dump freeze.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst || (clr && idle)) begin
        drop_q[c] <= '0;
      end else if (in_valid[c] && drop_q[c] != 16'hFFFF &&
                   (!idle || (full[c] && !wrap_mode))) begin
        drop_q[c] <= drop_q[c] + 16'd1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_drop
    assign drop_cnt[c*16 +: 16] = drop_q[c];
  end
`endif

endmodule
